// File: rtl/p_div_if.sv
// Request/response bundle for the packed-lane divider.
// The requester drives the operands and holds valid; the divider answers
// with a one-cycle ready pulse that qualifies result.
interface p_div_if;
    logic        valid;
    logic        ready;
    logic        div;
    logic [4:0]  pw;
    logic [31:0] crs1;
    logic [31:0] crs2;
    logic [31:0] result;

    modport master (
        output valid,
        output div,
        output pw,
        output crs1,
        output crs2,
        input  ready,
        input  result
    );

    modport slave (
        input  valid,
        input  div,
        input  pw,
        input  crs1,
        input  crs2,
        output ready,
        output result
    );
endinterface

// File: rtl/p_div.sv
// Packed-lane unsigned restoring divider.
// The 32-bit operands are split into independent lanes of 32, 16, 8, 4 or 2
// bits (one-hot pw). Every lane retires one quotient bit per cycle, so an
// operation takes W steps regardless of how many lanes are active.
module p_div (
    input  logic     clock,
    input  logic     reset,
    p_div_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    // q_reg holds the dividend and shifts quotient bits in at the bottom;
    // r_reg holds the partial remainders, d_reg the divisors.
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    logic [31:0] d_reg;
    logic [4:0]  pw_reg;
    logic        div_reg;
    logic [4:0]  cnt_reg;

    logic        pw_legal;
    logic        last_step;
    logic [2:0]  width_sel;

    // One candidate next-step value per supported lane width.
    logic [4:0][31:0] step_q;
    logic [4:0][31:0] step_r;

    // A lane width is legal only when exactly one pw bit is set.
    assign pw_legal = (bus.pw != 5'd0) && ((bus.pw & (bus.pw - 5'd1)) == 5'd0);

    // Lane datapath: for width index gi the lane width is 32 >> gi. The
    // subtraction is two bits wider than the lane so that a set MSB in
    // {R, dividend MSB} is never confused with a borrow (matters for a zero
    // divisor, where the remainder accumulates the whole dividend).
    genvar gi, gj;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_width
            localparam int W  = 32 >> gi;
            localparam int NL = 32 / W;
            for (gj = 0; gj < NL; gj++) begin : g_lane
                logic [W:0]   r_shift;
                logic [W+1:0] diff;
                logic         borrow;

                assign r_shift = {r_reg[gj*W +: W], q_reg[gj*W + W - 1]};
                assign diff    = {1'b0, r_shift} - {2'b00, d_reg[gj*W +: W]};
                assign borrow  = diff[W+1];

                assign step_r[gi][gj*W +: W] = borrow ? r_shift[W-1:0] : diff[W-1:0];
                assign step_q[gi][gj*W +: W] = {q_reg[gj*W +: W-1], ~borrow};
            end
        end
    endgenerate

    // Map the captured one-hot width to a step-array index and its final count.
    always_comb begin
        width_sel = 3'd0;
        last_step = 1'b1;
        case (pw_reg)
            5'b00001: begin width_sel = 3'd0; last_step = (cnt_reg == 5'd31); end
            5'b00010: begin width_sel = 3'd1; last_step = (cnt_reg == 5'd15); end
            5'b00100: begin width_sel = 3'd2; last_step = (cnt_reg == 5'd7);  end
            5'b01000: begin width_sel = 3'd3; last_step = (cnt_reg == 5'd3);  end
            5'b10000: begin width_sel = 3'd4; last_step = (cnt_reg == 5'd1);  end
            default:  begin width_sel = 3'd0; last_step = 1'b1;               end
        endcase
    end

    // State register; reset wins over everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; dropping valid outside IDLE aborts the operation.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.valid) begin
                    state_next = pw_legal ? RUN : DONE;
                end
            end
            RUN: begin
                if (!bus.valid) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs: the completion pulse is suppressed when the request was
    // withdrawn in the DONE cycle, and result is forced to zero otherwise.
    always_comb begin
        bus.ready  = 1'b0;
        bus.result = 32'd0;
        if ((state_reg == DONE) && bus.valid) begin
            bus.ready  = 1'b1;
            bus.result = div_reg ? q_reg : r_reg;
        end
    end

    // Datapath registers: capture in IDLE, step in RUN, clear on abort/exit.
    // An illegal width captures zeros so the DONE cycle reports result 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_reg   <= 32'd0;
            r_reg   <= 32'd0;
            d_reg   <= 32'd0;
            pw_reg  <= 5'd0;
            div_reg <= 1'b0;
            cnt_reg <= 5'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.valid) begin
                        r_reg   <= 32'd0;
                        cnt_reg <= 5'd0;
                        if (pw_legal) begin
                            q_reg   <= bus.crs1;
                            d_reg   <= bus.crs2;
                            pw_reg  <= bus.pw;
                            div_reg <= bus.div;
                        end else begin
                            q_reg   <= 32'd0;
                            d_reg   <= 32'd0;
                            pw_reg  <= 5'd0;
                            div_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (!bus.valid) begin
                        q_reg   <= 32'd0;
                        r_reg   <= 32'd0;
                        d_reg   <= 32'd0;
                        pw_reg  <= 5'd0;
                        div_reg <= 1'b0;
                        cnt_reg <= 5'd0;
                    end else begin
                        q_reg   <= step_q[width_sel];
                        r_reg   <= step_r[width_sel];
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                default: begin
                    q_reg   <= 32'd0;
                    r_reg   <= 32'd0;
                    d_reg   <= 32'd0;
                    pw_reg  <= 5'd0;
                    div_reg <= 1'b0;
                    cnt_reg <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p_div.sv
// Scoreboard bench for p_div: the driver pushes the hand-computed result and
// expected latency for each request; a negedge monitor pops and compares on
// every ready pulse and checks that result is zero whenever ready is low.
module tb_p_div;

    logic clock;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    logic mon_en;

    typedef struct {
        logic [31:0] res;
        int          start;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    p_div_if bus_if ();

    p_div dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: one line per completed transaction.
    always @(negedge clock) begin
        if (mon_en) begin
            if (bus_if.ready !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready cycle=%0d result=%08h required=no ready", cyc, bus_if.result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (bus_if.result !== e.res) begin
                        errors++;
                        $display("FAIL result got=%08h required=%08h", bus_if.result, e.res);
                    end
                    checks++;
                    if ((cyc - e.start) != e.lat) begin
                        errors++;
                        $display("FAIL latency got=%0d required=%0d", cyc - e.start, e.lat);
                    end else begin
                        $display("txn result=%08h latency=%0d", bus_if.result, cyc - e.start);
                    end
                end
            end else begin
                checks++;
                if (bus_if.result !== 32'd0) begin
                    errors++;
                    $display("FAIL idle_result cycle=%0d got=%08h required=00000000", cyc, bus_if.result);
                end
            end
        end
    end

    // Drive a request during the current cycle (cycle 0 of the operation).
    task automatic start_op(input logic [4:0] pw, input logic [31:0] c1, input logic [31:0] c2,
                            input logic dv, input logic [31:0] res, input int lat, input bit push);
        exp_t e;
        @(posedge clock);
        #1;
        bus_if.pw    = pw;
        bus_if.crs1  = c1;
        bus_if.crs2  = c2;
        bus_if.div   = dv;
        bus_if.valid = 1'b1;
        if (push) begin
            e.res   = res;
            e.start = cyc;
            e.lat   = lat;
            exp_q.push_back(e);
        end
    endtask

    // Wait (bounded) for the ready pulse; a timeout counts as a failure.
    task automatic wait_ready();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus_if.ready === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ready_timeout got=no ready required=ready within 60 cycles");
        end
    endtask

    task automatic end_op();
        @(posedge clock);
        #1;
        bus_if.valid = 1'b0;
    endtask

    task automatic run_op(input logic [4:0] pw, input logic [31:0] c1, input logic [31:0] c2,
                          input logic dv, input logic [31:0] res, input int lat);
        start_op(pw, c1, c2, dv, res, lat, 1'b1);
        wait_ready();
        end_op();
    endtask

    initial begin
        exp_t e;
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        mon_en       = 1'b0;
        reset        = 1'b1;
        bus_if.valid = 1'b0;
        bus_if.div   = 1'b0;
        bus_if.pw    = 5'd0;
        bus_if.crs1  = 32'd0;
        bus_if.crs2  = 32'd0;
        @(posedge clock);
        #1;
        mon_en = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);

        // 32-bit lane
        run_op(5'b00001, 32'd100, 32'd7, 1'b1, 32'd14, 33);
        run_op(5'b00001, 32'd100, 32'd7, 1'b0, 32'd2, 33);
        run_op(5'b00001, 32'hFFFFFFFF, 32'd0, 1'b1, 32'hFFFFFFFF, 33);
        run_op(5'b00001, 32'hFFFFFFFF, 32'd0, 1'b0, 32'hFFFFFFFF, 33);
        // 16-bit lanes
        run_op(5'b00010, 32'h12345678, 32'h00100007, 1'b1, 32'h01230C5A, 17);
        run_op(5'b00010, 32'h12345678, 32'h00100007, 1'b0, 32'h00040002, 17);
        // 8-bit lanes, one lane divides by zero
        run_op(5'b00100, 32'h64FF1007, 32'h07100300, 1'b1, 32'h0E0F05FF, 9);
        run_op(5'b00100, 32'h64FF1007, 32'h07100300, 1'b0, 32'h020F0107, 9);
        // 4-bit lanes
        run_op(5'b01000, 32'h87654321, 32'h22222222, 1'b1, 32'h43322110, 5);
        // 2-bit lanes
        run_op(5'b10000, 32'hFFFFFFFF, 32'h55555555, 1'b1, 32'hFFFFFFFF, 3);
        run_op(5'b10000, 32'hFFFFFFFF, 32'h55555555, 1'b0, 32'h00000000, 3);
        // Illegal widths complete immediately with zero
        run_op(5'b00011, 32'h12345678, 32'h00000003, 1'b1, 32'd0, 1);
        run_op(5'b00000, 32'h12345678, 32'h00000003, 1'b0, 32'd0, 1);

        // Abort a 16-bit op at cycle 5, then re-issue with a fresh latency
        start_op(5'b00010, 32'h12345678, 32'h00100007, 1'b1, 32'd0, 0, 1'b0);
        repeat (5) @(posedge clock);
        #1;
        bus_if.valid = 1'b0;
        repeat (25) @(posedge clock);
        run_op(5'b00010, 32'h12345678, 32'h00100007, 1'b1, 32'h01230C5A, 17);

        // Reset at cycle 3 of a 32-bit op with valid still high: reset wins,
        // then the held request starts afresh from the following IDLE cycle.
        start_op(5'b00001, 32'd100, 32'd7, 1'b1, 32'd0, 0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        e.res   = 32'd14;
        e.start = cyc;
        e.lat   = 33;
        exp_q.push_back(e);
        wait_ready();
        end_op();

        // Operand changes during RUN must not disturb the captured request
        start_op(5'b00001, 32'd100, 32'd7, 1'b0, 32'd2, 33, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        bus_if.crs1 = 32'hFFFFFFFF;
        bus_if.crs2 = 32'd1;
        bus_if.div  = 1'b1;
        bus_if.pw   = 5'b00100;
        wait_ready();
        end_op();

        // Valid held past ready starts a second back-to-back operation
        start_op(5'b10000, 32'h1B1B1B1B, 32'hAAAAAAAA, 1'b1, 32'h05050505, 3, 1'b1);
        wait_ready();
        @(posedge clock);
        #1;
        e.res   = 32'h05050505;
        e.start = cyc;
        e.lat   = 3;
        exp_q.push_back(e);
        wait_ready();
        end_op();

        repeat (5) @(posedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending got=%0d required=0", exp_q.size());
        end
        @(negedge clock);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
